// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Double-buffers hex values, inserts blanking gaps and suppresses leading zeros.
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned REFRESH_DIV   = 100000,
    parameter int unsigned BLANK_CYCLES  = 1000,
    parameter int unsigned BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    value_valid,
    output logic                    value_ready,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int unsigned TimerMax = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int unsigned TW       = (TimerMax > 1) ? $clog2(TimerMax) : 1;
    localparam int unsigned IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [TW-1:0] BlankLast = TW'(BLANK_CYCLES - 1);
    localparam logic [TW-1:0] DriveLast = TW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IdxLast   = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        StBlank,
        StDrive
    } state_e;

    state_e                  r_state;
    logic [TW-1:0]           r_timer;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic                    r_pending;
    logic                    r_frame_start;

    state_e        w_state_d;
    logic [TW-1:0] w_timer_d;
    logic [IW-1:0] w_idx_d;
    logic          w_pending_d;
    logic          w_xfer;
    logic          w_timer_done;
    logic          w_frame_end;
    logic          w_commit;

    logic [3:0]    w_nib;
    logic          w_dp_bit;
    logic          w_upper_zero;
    logic          w_blank_digit;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        unique case (nib)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    assign w_xfer       = value_valid & ~r_pending;
    assign w_timer_done = (r_state == StBlank) ? (r_timer == BlankLast) : (r_timer == DriveLast);
    assign w_frame_end  = enable && (r_state == StDrive) && w_timer_done && (r_idx == IdxLast);
    // A disabled display still commits, so the producer is never stalled by enable.
    assign w_commit     = r_pending && (w_frame_end || !enable);

    always_comb begin
        w_state_d = r_state;
        w_timer_d = r_timer + 1'b1;
        w_idx_d   = r_idx;
        if (!enable) begin
            w_state_d = StBlank;
            w_timer_d = '0;
            w_idx_d   = '0;
        end else begin
            unique case (r_state)
                StBlank: begin
                    if (w_timer_done) begin
                        w_state_d = StDrive;
                        w_timer_d = '0;
                    end
                end
                StDrive: begin
                    if (w_timer_done) begin
                        w_state_d = StBlank;
                        w_timer_d = '0;
                        w_idx_d   = (r_idx == IdxLast) ? '0 : r_idx + 1'b1;
                    end
                end
                default: begin
                    w_state_d = StBlank;
                    w_timer_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_pending_d = r_pending;
        if (w_xfer) begin
            w_pending_d = 1'b1;
        end else if (w_commit) begin
            w_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StBlank;
            r_timer       <= '0;
            r_idx         <= '0;
            r_shadow      <= '0;
            r_shadow_dp   <= '0;
            r_disp        <= '0;
            r_disp_dp     <= '0;
            r_pending     <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_timer       <= w_timer_d;
            r_idx         <= w_idx_d;
            r_pending     <= w_pending_d;
            r_frame_start <= w_frame_end;
            if (w_xfer) begin
                r_shadow    <= value;
                r_shadow_dp <= dp_mask;
            end
            if (w_commit) begin
                r_disp    <= r_shadow;
                r_disp_dp <= r_shadow_dp;
            end
        end
    end

    // Select the current nibble and find whether it and every higher nibble are zero.
    always_comb begin
        w_nib         = '0;
        w_dp_bit      = 1'b0;
        w_upper_zero  = 1'b1;
        w_blank_digit = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_upper_zero = w_upper_zero && (r_disp[4*i +: 4] == 4'h0);
            if (r_idx == IW'(i)) begin
                w_nib    = r_disp[4*i +: 4];
                w_dp_bit = r_disp_dp[i];
                w_blank_digit = (BLANK_LEADING != 0) && (i != 0) && w_upper_zero;
            end
        end
    end

    always_comb begin
        an  = '1;
        seg = 7'h7F;
        dp  = 1'b1;
        if ((r_state == StDrive) && !w_blank_digit) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (r_idx == IW'(i)) begin
                    an[i] = 1'b0;
                end
            end
            seg = hex_glyph(w_nib);
            dp  = ~w_dp_bit;
        end
    end

    assign value_ready = ~r_pending;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: a queue of accepted values is popped at each
// frame boundary and every cycle of selected frames is compared to a display model.
module tb_seg_scan_ctrl;

    localparam int ND   = 4;
    localparam int RD   = 4;
    localparam int BC   = 1;
    localparam int SLOT = BC + RD;
    localparam int FL   = ND * SLOT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic        value_valid;
    logic        value_ready;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    typedef struct {
        logic [15:0] v;
        logic [3:0]  d;
        int          c;
    } item_t;

    item_t       q[$];
    logic [15:0] cur_v = '0;
    logic [3:0]  cur_d = '0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        drop_valid = 1'b0;
    logic [3:0]  prev_an = 4'hF;

    seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC),
        .BLANK_LEADING(1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .value      (value),
        .dp_mask    (dp_mask),
        .value_valid(value_valid),
        .value_ready(value_ready),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // Expected {an, seg, dp} at cycle k of a frame showing v/d.
    function automatic logic [11:0] exp_out(input logic [15:0] v, input logic [3:0] d, input int k);
        int         slot = k / SLOT;
        int         pos  = k % SLOT;
        logic [3:0] a    = 4'hF;
        if (pos < BC) return 12'hFFF;
        if (slot > 0 && (v >> (4 * slot)) == 16'h0) return 12'hFFF;
        a[slot] = 1'b0;
        return {a, glyph(v[4*slot +: 4]), ~d[slot]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (drop_valid) begin
            value_valid = 1'b0;
            drop_valid  = 1'b0;
        end
        if (rst_n && frame_start) begin
            // An item transferred on the boundary edge itself is not committed yet.
            if (q.size() > 0 && q[0].c <= cyc - 2) begin
                cur_v = q[0].v;
                cur_d = q[0].d;
                void'(q.pop_front());
            end
            chk("ready_at_frame", {31'd0, value_ready}, {31'd0, q.size() == 0});
        end
    endtask

    task automatic offer(input logic [15:0] v, input logic [3:0] d, output int n);
        drop_valid  = 1'b0;
        value       = v;
        dp_mask     = d;
        value_valid = 1'b1;
        n = 0;
        while (!value_ready && n < 3 * FL) begin
            tick();
            n++;
        end
        chk("offer_accept", {31'd0, value_ready}, 32'd1);
        if (value_ready) q.push_back('{v: v, d: d, c: cyc});
        drop_valid = 1'b1;
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_start && n < 3 * FL);
        chk("frame_start_seen", {31'd0, frame_start}, 32'd1);
    endtask

    task automatic check_frame(input int k0, input bit fs_first);
        logic [15:0] lv = cur_v;
        logic [3:0]  ld = cur_d;
        for (int k = k0; k < FL; k++) begin
            if (k > k0) tick();
            chk($sformatf("disp %h k=%0d", lv, k), {20'd0, an, seg, dp}, {20'd0, exp_out(lv, ld, k)});
            chk($sformatf("fs k=%0d", k), {31'd0, frame_start}, {31'd0, (k == 0) && fs_first});
        end
    endtask

    task automatic frame();
        int n;
        wait_fs(n);
        check_frame(0, 1'b1);
    endtask

    // Anti-ghosting: never two anodes low, and never a direct switch between digits.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("an_onehot0", {31'd0, $onehot0(~an)}, 32'd1);
            if (prev_an != 4'hF && an != 4'hF) chk("blank_gap", {28'd0, an}, {28'd0, prev_an});
        end
        prev_an <= an;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; enable = 1'b1; value = '0; dp_mask = '0; value_valid = 1'b0;

        // Reset state and first DRIVE after release.
        tick();
        chk("rst_out", {20'd0, an, seg, dp}, 32'hFFF);
        chk("rst_ready", {31'd0, value_ready}, 32'd1);
        chk("rst_fs", {31'd0, frame_start}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("first_drive", {20'd0, an, seg, dp}, {20'd0, exp_out(16'h0, 4'h0, 1)});
        offer(16'h4321, 4'h0, n);
        tick();
        chk("pend_ready_low", {31'd0, value_ready}, 32'd0);

        // Mid-clock asynchronous reset.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out", {20'd0, an, seg, dp}, 32'hFFF);
        chk("async_rst_ready", {31'd0, value_ready}, 32'd1);
        q.delete();
        cur_v = '0;
        cur_d = '0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_exit_drive0", {20'd0, an, seg, dp}, {20'd0, exp_out(16'h0, 4'h0, 1)});
        wait_fs(n);
        chk("first_frame_len", n, FL - 1);
        check_frame(0, 1'b1);

        // Double-buffered update with leading blanking and decimal point.
        offer(16'h00A5, 4'b0010, n);
        tick();
        chk("a5_ready_low", {31'd0, value_ready}, 32'd0);
        frame();

        // Backpressure: 5678 waits for the 1234 commit.
        offer(16'h1234, 4'b0000, n);
        tick();
        chk("bp_ready_low", {31'd0, value_ready}, 32'd0);
        offer(16'h5678, 4'b0101, n);
        chk("bp_accept_at_commit", {31'd0, frame_start}, 32'd1);
        chk("bp_wait_len", n, FL);
        check_frame(0, 1'b1);

        // All-zero and top-nibble-only values.
        offer(16'h0000, 4'b0000, n);
        frame();
        offer(16'h1000, 4'b0000, n);
        frame();
        frame();

        // Disable during DRIVE of digit 2, accept while dark, re-enable.
        wait_fs(n);
        repeat (2 * SLOT + 2) tick();
        chk("pre_disable_d2", {28'd0, an}, 32'hB);
        enable = 1'b0;
        repeat (3) begin
            tick();
            chk("disabled_out", {20'd0, an, seg, dp}, 32'hFFF);
            chk("disabled_fs", {31'd0, frame_start}, 32'd0);
        end
        offer(16'h0C0D, 4'b1000, n);
        tick();
        chk("dis_ready_low", {31'd0, value_ready}, 32'd0);
        tick();
        chk("dis_commit_ready", {31'd0, value_ready}, 32'd1);
        cur_v = q[0].v;
        cur_d = q[0].d;
        void'(q.pop_front());
        enable = 1'b1;
        check_frame(0, 1'b0);
        wait_fs(n);
        chk("reenable_frame_len", n, 1);
        check_frame(0, 1'b1);

        // Random values over several frames.
        for (int i = 0; i < 5; i++) begin
            offer(16'($urandom) >> (4 * $urandom_range(0, 3)), 4'($urandom), n);
            frame();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
